pipeline_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage ARM pipeline (IF, ID, EXE, MEM, WB).
- Replaces the constant-0 flush/freeze nets with per-stage control.
- Detects RAW hazards in ID, stalls the back end during multi-cycle data-memory accesses through a ready handshake, and flushes IF/ID on a taken branch.
- Keeps a sticky memory-timeout flag and a stall-cycle counter.

---
 rtl/pipeline_hazard_ctrl_if.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and per-stage control outputs.
// The master modport is the pipeline side; the slave modport is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_use_src1;
  logic             id_use_src2;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;
  logic             freeze_front;
  logic             bubble_idex;
  logic             freeze_back;
  logic             flush_ifid;
  logic [1:0]       fwd_sel1;
  logic [1:0]       fwd_sel2;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_src1, id_src2, id_use_src1, id_use_src2,
    output exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en, mem_req, mem_ready, branch_taken,
    input  freeze_front, bubble_idex, freeze_back, flush_ifid,
    input  fwd_sel1, fwd_sel2, mem_timeout, stall_cycles
  );

  modport slave (
    input  id_src1, id_src2, id_use_src1, id_use_src2,
    input  exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en, mem_req, mem_ready, branch_taken,
    output freeze_front, bubble_idex, freeze_back, flush_ifid,
    output fwd_sel1, fwd_sel2, mem_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage ARM pipeline (RAW, memory wait, branch flush).
// Optional macro FORWARDING_EN: forward EXE/MEM results and stall only on load-use.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERROR} state_t;

  state_t            r_state, w_state_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_cnt_next;
  logic              r_timeout, w_set_timeout, w_mem_stall;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic [3:0] w_src [2];
  logic [1:0] w_fwd [2];
  logic [1:0] w_use, w_match_exe, w_match_mem, w_hazard_src;
  logic       w_hazard, w_run, w_freeze_front;

  assign w_src[0] = bus.id_src1;
  assign w_src[1] = bus.id_src2;
  assign w_use    = {bus.id_use_src2, bus.id_use_src1};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_match_exe[gi] = w_use[gi] & bus.exe_wb_en & (w_src[gi] == bus.exe_dest);
      assign w_match_mem[gi] = w_use[gi] & bus.mem_wb_en & (w_src[gi] == bus.mem_dest);
`ifdef FORWARDING_EN
      // Only a load in EXE cannot be bypassed; EXE results win over older MEM results.
      assign w_hazard_src[gi] = w_match_exe[gi] & bus.exe_mem_r_en;
      assign w_fwd[gi] = (w_match_exe[gi] & ~bus.exe_mem_r_en) ? 2'd1 :
                         w_match_mem[gi]                        ? 2'd2 : 2'd0;
`else
      assign w_hazard_src[gi] = w_match_exe[gi] | w_match_mem[gi];
      assign w_fwd[gi]        = 2'd0;
`endif
    end
  endgenerate

`ifndef FORWARDING_EN
  logic w_unused_ld;
  assign w_unused_ld = bus.exe_mem_r_en;
`endif

  assign w_hazard = |w_hazard_src;

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_mem_stall     = 1'b0;
    w_set_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mem_req && !bus.mem_ready) begin
          w_mem_stall     = 1'b1;
          w_state_next    = ST_WAIT;
          w_wait_cnt_next = WAIT_W'(1);
        end
      end
      ST_WAIT: begin
        if (bus.mem_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_mem_stall     = 1'b1;
          w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
          // The cycle that brings the count to TIMEOUT is the last stalled one.
          if ((TIMEOUT != 0) && (int'(r_wait_cnt) + 1 >= TIMEOUT)) begin
            w_state_next  = ST_ERROR;
            w_set_timeout = 1'b1;
          end
        end
      end
      ST_ERROR: begin
        w_state_next = ST_ERROR;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Gating with the reset input keeps every control output low while reset is held.
  assign w_run          = rst;
  assign w_freeze_front = w_run & (w_mem_stall | (w_hazard & ~bus.branch_taken));

  assign bus.freeze_front = w_freeze_front;
  assign bus.freeze_back  = w_run & w_mem_stall;
  assign bus.bubble_idex  = w_run & ~w_mem_stall & (w_hazard | bus.branch_taken);
  assign bus.flush_ifid   = w_run & ~w_mem_stall & bus.branch_taken;
  assign bus.fwd_sel1     = w_run ? w_fwd[0] : 2'd0;
  assign bus.fwd_sel2     = w_run ? w_fwd[1] : 2'd0;
  assign bus.mem_timeout  = r_timeout;
  assign bus.stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= ST_IDLE;
      r_wait_cnt     <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
      if (w_freeze_front && !(&r_stall_cycles)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
    end
  end
endmodule
